uart_sector_writer: RTL

Serial-to-SD capture path: deserialises 8N1 UART bytes from the soft core's serial output, packs them into 512-byte sectors in the SD sector buffer, and commits each full sector to the HPS-backed image with an `sd_wr`/`sd_ack` handshake. This is the reverse of the HEX loader path, which reads sectors and serialises them into the core; it lets the core stream save data or logs back to the SD image.

---
 rtl/arduboy_pkg.sv | 24 ++
 rtl/uart_rx_core.sv | 112 +++++++++++
 rtl/uart_sector_writer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/arduboy_pkg.sv
// Shared types and constants for the serial-to-SD capture path.
// Holds RX/sector state enums, sector size, pad byte and holding depth.
package arduboy_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        SEC_FILL,
        SEC_PAD,
        SEC_COMMIT,
        SEC_RELEASE
    } sec_state_e;

    localparam int SECTOR_BYTES = 512;
    // Same EOF marker the HEX loader stops on.
    localparam logic [7:0] PAD_BYTE = 8'h1A;
    localparam int HOLD_DEPTH = 16;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-FF synchroniser, RX FSM, bit counter.
// Ports: clk, reset (sync, active-high), rxd in; rx_byte, valid, frame_err (1-cycle pulses) out.
module uart_rx_core
    import arduboy_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       valid,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_e     state_q, state_d;
    logic          sync1_q, sync1_d, sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          armed_q, armed_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    always_comb begin
        state_d = state_q;
        sync1_d = rxd;
        sync2_d = sync1_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        armed_d = armed_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                // Only a high-to-low transition starts a frame, so a held
                // break does not retrigger.
                if (sync2_q) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    armed_d = 1'b0;
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    bit_d = '0;
                    if (sync2_q) begin
                        armed_d = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    armed_d = sync2_q;
                    valid_d = sync2_q;
                    ferr_d  = !sync2_q;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RX_IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            armed_q <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            armed_q <= armed_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_byte   = shift_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;

endmodule

// File: rtl/uart_sector_writer.sv
// Packs UART bytes into 512-byte sectors and commits them via sd_wr/sd_ack.
// Ports: clk_100m, reset, rxd, flush, sd_ack in; buf_addr/din/wr, sd_lba, sd_wr,
// busy, overrun, frame_err out. SECTOR_WRITER_FIFO_EN: 16-entry holding FIFO.
module uart_sector_writer
    import arduboy_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int START_LBA    = 0
) (
    input  logic       clk_100m,
    input  logic       reset,
    input  logic       rxd,
    input  logic       flush,
    output logic [8:0] buf_addr,
    output logic [7:0] buf_din,
    output logic       buf_wr,
    output logic [8:0] sd_lba,
    output logic       sd_wr,
    input  logic       sd_ack,
    output logic       busy,
    output logic       overrun,
    output logic       frame_err
);

    localparam logic [8:0] LAST_ADDR = 9'(SECTOR_BYTES - 1);

    logic [7:0] rx_byte;
    logic       rx_valid, rx_ferr;

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (clk_100m),
        .reset     (reset),
        .rxd       (rxd),
        .rx_byte   (rx_byte),
        .valid     (rx_valid),
        .frame_err (rx_ferr)
    );

    logic       pop, accept, hold_empty, hold_full;
    logic [7:0] hold_head;

    // A push into a full stage is still accepted when a pop frees a slot.
    assign accept = rx_valid && (!hold_full || pop);

`ifdef SECTOR_WRITER_FIFO_EN
    logic [7:0] mem_q [HOLD_DEPTH];
    logic [3:0] rd_q, rd_d, wr_q, wr_d;
    logic [4:0] cnt_q, cnt_d;

    assign hold_empty = (cnt_q == 5'd0);
    assign hold_full  = (cnt_q == 5'(HOLD_DEPTH));
    assign hold_head  = mem_q[rd_q];

    always_comb begin
        rd_d  = rd_q + 4'(pop);
        wr_d  = wr_q + 4'(accept);
        cnt_d = cnt_q + 5'(accept) - 5'(pop);
    end

    always_ff @(posedge clk_100m) begin
        if (accept) mem_q[wr_q] <= rx_byte;
    end

    always_ff @(posedge clk_100m) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end
`else
    logic       hold_vld_q, hold_vld_d;
    logic [7:0] hold_byte_q, hold_byte_d;

    assign hold_empty = !hold_vld_q;
    assign hold_full  = hold_vld_q;
    assign hold_head  = hold_byte_q;

    always_comb begin
        hold_vld_d  = hold_vld_q && !pop;
        hold_byte_d = hold_byte_q;
        if (accept) begin
            hold_vld_d  = 1'b1;
            hold_byte_d = rx_byte;
        end
    end

    always_ff @(posedge clk_100m) begin
        if (reset) begin
            hold_vld_q  <= 1'b0;
            hold_byte_q <= '0;
        end else begin
            hold_vld_q  <= hold_vld_d;
            hold_byte_q <= hold_byte_d;
        end
    end
`endif

    sec_state_e state_q, state_d;
    logic [8:0] ptr_q, ptr_d, lba_q, lba_d, addr_q, addr_d;
    logic [7:0] din_q, din_d;
    logic       wr_q_o, wr_d_o, sdwr_q, sdwr_d, busy_q, busy_d;
    logic       fpend_q, fpend_d, ovr_q, ovr_d, ferr_q, ferr_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lba_d   = lba_q;
        addr_d  = addr_q;
        din_d   = din_q;
        wr_d_o  = 1'b0;
        pop     = 1'b0;
        fpend_d = fpend_q || flush;
        unique case (state_q)
            SEC_FILL: begin
                if (!hold_empty) begin
                    pop    = 1'b1;
                    wr_d_o = 1'b1;
                    addr_d = ptr_q;
                    din_d  = hold_head;
                    ptr_d  = ptr_q + 9'd1;
                    if (ptr_q == LAST_ADDR) begin
                        // A full sector already satisfies an older flush.
                        fpend_d = flush;
                        state_d = SEC_COMMIT;
                    end
                end else if (fpend_q) begin
                    fpend_d = flush;
                    if (ptr_q != 9'd0) state_d = SEC_PAD;
                end
            end
            SEC_PAD: begin
                wr_d_o = 1'b1;
                addr_d = ptr_q;
                din_d  = PAD_BYTE;
                ptr_d  = ptr_q + 9'd1;
                if (ptr_q == LAST_ADDR) state_d = SEC_COMMIT;
            end
            SEC_COMMIT: begin
                if (sdwr_q && sd_ack) state_d = SEC_RELEASE;
            end
            SEC_RELEASE: begin
                if (!sd_ack) begin
                    lba_d   = lba_q + 9'd1;
                    ptr_d   = '0;
                    state_d = SEC_FILL;
                end
            end
            default: state_d = SEC_FILL;
        endcase
        // Request rises one cycle after entering COMMIT, drops once ack seen.
        sdwr_d = (state_q == SEC_COMMIT) && !(sdwr_q && sd_ack);
        busy_d = (state_d != SEC_FILL);
        ovr_d  = ovr_q || (rx_valid && !accept);
        ferr_d = ferr_q || rx_ferr;
    end

    always_ff @(posedge clk_100m) begin
        if (reset) begin
            state_q <= SEC_FILL;
            ptr_q   <= '0;
            lba_q   <= 9'(START_LBA);
            addr_q  <= '0;
            din_q   <= '0;
            wr_q_o  <= 1'b0;
            sdwr_q  <= 1'b0;
            busy_q  <= 1'b0;
            fpend_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lba_q   <= lba_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            wr_q_o  <= wr_d_o;
            sdwr_q  <= sdwr_d;
            busy_q  <= busy_d;
            fpend_q <= fpend_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign buf_addr  = addr_q;
    assign buf_din   = din_q;
    assign buf_wr    = wr_q_o;
    assign sd_lba    = lba_q;
    assign sd_wr     = sdwr_q;
    assign busy      = busy_q;
    assign overrun   = ovr_q;
    assign frame_err = ferr_q;

endmodule
